// File: rtl/dense_row_sched_if.sv
// Row-fetch, engine and collected-output buses of the dense row scheduler.
// master = scheduler side, slave = feature buffer / engine / consumer side.
interface dense_row_sched_if #(
  parameter int H          = 3,
  parameter int W          = 3,
  parameter int D          = 12,
  parameter int B          = 64,
  parameter int DATA_WIDTH = 8
);
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int OW = (B > 1) ? $clog2(B) : 1;
  localparam int PW = W * D * DATA_WIDTH;

  logic                         row_req_o;
  logic [RW-1:0]                row_addr_o;
  logic                         row_valid_i;
  logic [PW-1:0]                row_data_i;
  logic                         eng_rstn_o;
  logic                         eng_valid_o;
  logic [PW-1:0]                eng_data_o;
  logic                         eng_valid_i;
  logic signed [DATA_WIDTH-1:0] eng_data_i;
  logic                         out_valid_o;
  logic [OW-1:0]                out_idx_o;
  logic [DATA_WIDTH-1:0]        out_data_o;

  modport master (
    output row_req_o, row_addr_o, input row_valid_i, row_data_i,
    output eng_rstn_o, eng_valid_o, eng_data_o, input eng_valid_i, eng_data_i,
    output out_valid_o, out_idx_o, out_data_o
  );
  modport slave (
    input row_req_o, row_addr_o, output row_valid_i, row_data_i,
    input eng_rstn_o, eng_valid_o, eng_data_o, output eng_valid_i, eng_data_i,
    input out_valid_o, out_idx_o, out_data_o
  );
endinterface

// File: rtl/dense_row_sched.sv
// Sequences one dense-front engine over H rows of an image: clear, fetch/issue
// each row with fixed spacing, then collect the B outputs of the last row.
module dense_row_sched #(
  parameter int H          = 3,
  parameter int W          = 3,
  parameter int D          = 12,
  parameter int B          = 64,
  parameter int DATA_WIDTH = 8,
  parameter int ROW_CYC    = 2 * B,
  parameter int TIMEOUT    = 4 * B
) (
  input  logic clk,
  input  logic rstn,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  output logic err_o,
  dense_row_sched_if.master bus
);
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int OW = (B > 1) ? $clog2(B) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, ISSUE, RUN, DRAIN, DONE} state_t;

  state_t                       state, state_nxt;
  logic [RW-1:0]                row_cnt, row_cnt_nxt;
  logic [TW-1:0]                cyc_cnt, cyc_cnt_nxt;
  logic [TW-1:0]                wd_cnt, wd_cnt_nxt;
  logic [OW-1:0]                out_cnt, out_cnt_nxt;
  logic                         err_nxt, accept, drain_last;
  logic [W*D*DATA_WIDTH-1:0]    row_data;
  logic signed [DATA_WIDTH-1:0] eng_val;

  assign row_data = bus.row_data_i;
  assign eng_val  = bus.eng_data_i;
  // The last neuron is on the output register this cycle: image complete.
  assign drain_last = bus.out_valid_o && (bus.out_idx_o == OW'(B - 1));

  always_comb begin
    state_nxt   = state;
    row_cnt_nxt = row_cnt;
    cyc_cnt_nxt = cyc_cnt;
    wd_cnt_nxt  = wd_cnt;
    out_cnt_nxt = out_cnt;
    err_nxt     = err_o;
    accept      = 1'b0;
    case (state)
      IDLE: if (start_i) begin
        state_nxt   = CLEAR;
        err_nxt     = 1'b0;
        row_cnt_nxt = '0;
        out_cnt_nxt = '0;
      end
      CLEAR: state_nxt = FETCH;
      FETCH: if (bus.row_valid_i) state_nxt = ISSUE;
      ISSUE: begin
        if (row_cnt == RW'(H - 1)) begin
          state_nxt   = DRAIN;
          wd_cnt_nxt  = '0;
          out_cnt_nxt = '0;
        end else begin
          state_nxt   = RUN;
          cyc_cnt_nxt = '0;
        end
      end
      RUN: begin
        if (cyc_cnt == TW'(ROW_CYC - 1)) begin
          state_nxt   = FETCH;
          cyc_cnt_nxt = '0;
          row_cnt_nxt = row_cnt + 1'b1;
        end else begin
          cyc_cnt_nxt = cyc_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_last) begin
          state_nxt  = DONE;
          wd_cnt_nxt = '0;
        end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
          state_nxt  = DONE;
          err_nxt    = 1'b1;
          wd_cnt_nxt = '0;
        end else begin
          wd_cnt_nxt = wd_cnt + 1'b1;
          accept     = bus.eng_valid_i;
          if (accept) out_cnt_nxt = (out_cnt == OW'(B - 1)) ? '0 : out_cnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Engine strobes outside the collection window are dropped and flagged.
    if (bus.eng_valid_i && state != DRAIN) err_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= IDLE;
      row_cnt         <= '0;
      cyc_cnt         <= '0;
      wd_cnt          <= '0;
      out_cnt         <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      bus.row_req_o   <= 1'b0;
      bus.row_addr_o  <= '0;
      bus.eng_rstn_o  <= 1'b0;
      bus.eng_valid_o <= 1'b0;
      bus.eng_data_o  <= '0;
      bus.out_valid_o <= 1'b0;
      bus.out_idx_o   <= '0;
      bus.out_data_o  <= '0;
    end else begin
      state           <= state_nxt;
      row_cnt         <= row_cnt_nxt;
      cyc_cnt         <= cyc_cnt_nxt;
      wd_cnt          <= wd_cnt_nxt;
      out_cnt         <= out_cnt_nxt;
      err_o           <= err_nxt;
      busy_o          <= (state_nxt != IDLE);
      done_o          <= (state_nxt == DONE);
      bus.row_req_o   <= (state_nxt == FETCH);
      bus.row_addr_o  <= (state_nxt == FETCH) ? row_cnt_nxt : '0;
      bus.eng_rstn_o  <= (state_nxt != CLEAR);
      bus.eng_valid_o <= (state_nxt == ISSUE);
      // Payload held from ISSUE until the next fetch completes.
      if (state == FETCH && bus.row_valid_i) bus.eng_data_o <= row_data;
      bus.out_valid_o <= accept;
      if (accept) begin
        bus.out_idx_o  <= out_cnt;
        bus.out_data_o <= eng_val;
      end
    end
  end
endmodule

// File: tb/tb_dense_row_sched.sv
// Randomized scoreboard bench for dense_row_sched: upstream and engine models
// push expectations, negedge monitors pop and compare.
module tb_dense_row_sched;
  localparam int H = 3, W = 3, D = 12, B = 4, DW = 8, ROW_CYC = 8, TIMEOUT = 16;
  localparam int PW     = W * D * DW;
  localparam int LAT    = 4 + (H - 1) * (2 + ROW_CYC) + 2 * B;
  localparam int LAT_TO = 4 + (H - 1) * (2 + ROW_CYC) + TIMEOUT;

  typedef struct {int idx; logic [DW-1:0] data;} out_t;
  typedef struct {int cyc; bit err;} done_t;

  logic clk = 1'b0, rstn = 1'b0, start_i = 1'b0;
  logic busy_o, done_o, err_o;

  dense_row_sched_if #(.H(H), .W(W), .D(D), .B(B), .DATA_WIDTH(DW)) bus ();

  dense_row_sched #(.H(H), .W(W), .D(D), .B(B), .DATA_WIDTH(DW),
                    .ROW_CYC(ROW_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  logic [PW-1:0] exp_row_q[$];
  int            exp_addr_q[$];
  int            exp_gap_q[$];
  out_t          exp_out_q[$];
  done_t         exp_done_q[$];
  int stall_row = -1, stall_len = 0;
  bit silent = 1'b0, force_ev = 1'b0;
  int emit_left = 0, emit_gap = 0, emit_k = 0;
  int strobe_n = 0, last_strobe = 0, out_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_data(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Upstream feature buffer: answers a request immediately unless told to stall.
  initial begin
    logic [PW-1:0] d;
    int st;
    st = 0;
    bus.row_valid_i = 1'b0;
    bus.row_data_i  = '0;
    forever begin
      @(posedge clk); #1;
      bus.row_valid_i = 1'b0;
      if (rstn && bus.row_req_o) begin
        if (exp_addr_q.size() == 0) chk("row_req_unexpected", 1, 0);
        else begin
          chk("row_addr", int'(bus.row_addr_o), exp_addr_q[0]);
          if (exp_addr_q[0] == stall_row && st < stall_len) st++;
          else begin
            d = '0;
            for (int i = 0; i < (PW + 31) / 32; i++) d = (d << 32) | PW'($urandom);
            void'(exp_addr_q.pop_front());
            st = 0;
            bus.row_valid_i = 1'b1;
            bus.row_data_i  = d;
            exp_row_q.push_back(d);
          end
        end
      end
    end
  end

  // Engine: after the H-th row strobe, emits B values every second cycle.
  initial begin
    logic [DW-1:0] v;
    bus.eng_valid_i = 1'b0;
    bus.eng_data_i  = '0;
    forever begin
      @(posedge clk); #1;
      bus.eng_valid_i = force_ev;
      if (emit_left > 0) begin
        if (emit_gap > 0) emit_gap--;
        else begin
          v = DW'($urandom);
          bus.eng_valid_i = 1'b1;
          bus.eng_data_i  = v;
          exp_out_q.push_back('{emit_k, v});
          emit_k++;
          emit_left--;
          emit_gap = 1;
          if (emit_left == 0) exp_done_q.push_back('{cyc + 2, 1'b0});
        end
      end
    end
  end

  // Row strobe monitor: payload, spacing, and the trigger for the engine model.
  initial forever begin
    @(negedge clk);
    if (rstn && bus.eng_valid_o) begin
      if (exp_row_q.size() == 0) chk("eng_strobe_unexpected", 1, 0);
      else chk_data("eng_data", bus.eng_data_o, exp_row_q.pop_front());
      if (strobe_n > 0)
        chk("strobe_gap", cyc - last_strobe, (exp_gap_q.size() > 0) ? exp_gap_q.pop_front() : -1);
      last_strobe = cyc;
      strobe_n++;
      if (strobe_n == H) begin
        strobe_n = 0;
        if (silent) exp_done_q.push_back('{cyc + 1 + TIMEOUT, 1'b1});
        else begin
          emit_left = B;
          emit_gap  = 0;
          emit_k    = 0;
        end
      end
    end
  end

  // Output and done monitor.
  initial forever begin
    out_t  eo;
    done_t ed;
    @(negedge clk);
    if (rstn && bus.out_valid_o) begin
      out_seen++;
      if (exp_out_q.size() == 0) chk("out_unexpected", 1, 0);
      else begin
        eo = exp_out_q.pop_front();
        chk("out_idx", int'(bus.out_idx_o), eo.idx);
        chk("out_data", int'(bus.out_data_o), int'(eo.data));
      end
    end
    if (rstn && done_o) begin
      if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        ed = exp_done_q.pop_front();
        chk("done_cycle", cyc, ed.cyc);
        chk("done_err", int'(err_o), int'(ed.err));
      end
    end
  end

  task automatic queue_image(input int sr, input int sl);
    stall_row = sr;
    stall_len = sl;
    for (int r = 0; r < H; r++) exp_addr_q.push_back(r);
    for (int r = 1; r < H; r++) exp_gap_q.push_back(2 + ROW_CYC + ((r == sr) ? sl : 0));
  endtask

  task automatic wait_done(input int s, input int lat);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("done_timeout", 0, 1);
    else chk("latency", cyc - s, lat);
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; DUT must be idle.
  task automatic run_image(input int sr, input int sl, input bit sil, input int lat, input bit mid);
    int s;
    silent = sil;
    queue_image(sr, sl);
    s = cyc;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    chk("eng_rstn_clear", int'(bus.eng_rstn_o), 0);
    chk("busy_on", int'(busy_o), 1);
    chk("err_cleared", int'(err_o), 0);
    @(negedge clk);
    chk("eng_rstn_release", int'(bus.eng_rstn_o), 1);
    if (mid) begin
      repeat (4) @(posedge clk);
      #1 start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    wait_done(s, lat);
    silent = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_eng_rstn", int'(bus.eng_rstn_o), 0);
    chk("rst_flags", int'({busy_o, done_o, err_o, bus.row_req_o, bus.eng_valid_o, bus.out_valid_o}), 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk);
    repeat (20) begin
      @(negedge clk);
      chk("idle_flags", int'({busy_o, done_o, err_o, bus.row_req_o, bus.eng_valid_o,
                              bus.out_valid_o, bus.eng_rstn_o}), 1);
    end
    chk("idle_buses", int'(|{bus.row_addr_o, bus.out_idx_o, bus.out_data_o, bus.eng_data_o}), 0);

    // Stray engine strobe while idle.
    force_ev = 1'b1;
    @(negedge clk) force_ev = 1'b0;
    @(negedge clk);
    chk("err_protocol", int'(err_o), 1);
    @(posedge clk); #1;

    run_image(-1, 0, 1'b0, LAT, 1'b0);
    run_image(1, 5, 1'b0, LAT + 5, 1'b0);
    run_image(-1, 0, 1'b0, LAT, 1'b1);
    run_image(-1, 0, 1'b0, LAT, 1'b0);
    run_image(-1, 0, 1'b1, LAT_TO, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("err_sticky", int'(err_o), 1);
    end
    @(posedge clk); #1;
    run_image(-1, 0, 1'b0, LAT, 1'b0);

    // Reset in the middle of collection.
    queue_image(-1, 0);
    out_seen = 0;
    start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    n = 0;
    while (out_seen < 2 && n < 500) begin @(negedge clk); n++; end
    chk("drain_reached", int'(n < 500), 1);
    @(posedge clk); #2;
    rstn = 1'b0;
    emit_left = 0;
    bus.eng_valid_i = 1'b0;
    exp_out_q.delete(); exp_done_q.delete(); exp_row_q.delete();
    exp_addr_q.delete(); exp_gap_q.delete();
    strobe_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_flags", int'({busy_o, done_o, err_o, bus.row_req_o, bus.eng_valid_o,
                              bus.out_valid_o, bus.eng_rstn_o}), 0);
    chk("midrst_idx", int'(bus.out_idx_o), 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_idle", int'({busy_o, bus.eng_rstn_o}), 1);
    @(posedge clk); #1;
    run_image(-1, 0, 1'b0, LAT, 1'b0);

    repeat (4) @(negedge clk);
    chk("queues_empty", exp_out_q.size() + exp_done_q.size() + exp_row_q.size()
                        + exp_addr_q.size() + exp_gap_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #60000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end
endmodule
